// File: rtl/branch_target_predictor.sv
// Next-PC prediction and branch resolution unit.
// A direct-mapped BTB with 2-bit saturating direction counters answers fetch
// lookups combinationally. Resolved control flow from execute trains the
// table, produces a registered redirect one cycle later, and bumps two
// saturating performance counters.
module branch_target_predictor #(
    parameter int         XLEN     = 32,
    parameter int         ENTRIES  = 16,
    parameter logic [1:0] CTR_INIT = 2'b10,
    parameter int         CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst,
    // fetch-side lookup
    input  logic             f_valid,
    input  logic [XLEN-1:0]  f_pc,
    output logic             f_hit,
    output logic             f_pred_taken,
    output logic [XLEN-1:0]  f_next_pc,
    // execute-side resolution
    input  logic             ex_valid,
    input  logic [XLEN-1:0]  ex_pc,
    input  logic             ex_is_ctrl,
    input  logic             ex_is_jump,
    input  logic             ex_taken,
    input  logic [XLEN-1:0]  ex_target,
    input  logic             ex_pred_taken,
    input  logic [XLEN-1:0]  ex_pred_target,
    output logic             mispredict,
    output logic [XLEN-1:0]  redirect_pc,
    output logic [CNT_W-1:0] cnt_ctrl,
    output logic [CNT_W-1:0] cnt_mispred
);

    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_W = XLEN - 2 - IDX_W;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    // Flattened view of the per-entry state, driven from the generate loop.
    logic [ENTRIES-1:0] valid_vec;
    logic [TAG_W-1:0]   tag_vec    [ENTRIES];
    logic [XLEN-2:0]    target_vec [ENTRIES];
    logic [1:0]         ctr_vec    [ENTRIES];

    // Fetch address split
    logic [IDX_W-1:0] f_idx;
    logic [TAG_W-1:0] f_tag;
    assign f_idx = f_pc[IDX_W+1:2];
    assign f_tag = f_pc[XLEN-1:IDX_W+2];

    // Execute address split; target is stored without bit 0
    logic [IDX_W-1:0] ex_idx;
    logic [TAG_W-1:0] ex_tag;
    logic [XLEN-1:0]  ex_target_m;
    logic             ex_hit;
    assign ex_idx      = ex_pc[IDX_W+1:2];
    assign ex_tag      = ex_pc[XLEN-1:IDX_W+2];
    assign ex_target_m = {ex_target[XLEN-1:1], 1'b0};
    assign ex_hit      = valid_vec[ex_idx] && (tag_vec[ex_idx] == ex_tag);

    // Bits that carry no information for this unit (word-aligned fetch,
    // halfword-cleared targets).
    logic unused_bits;
    assign unused_bits = ^{f_pc[1:0], ex_target[0]};

    // Combinational lookup from the table registers; no bypass of a
    // same-cycle training write. Reset forces a miss.
    always_comb begin
        f_hit        = 1'b0;
        f_pred_taken = 1'b0;
        f_next_pc    = f_pc + XLEN'(4);
        if (f_valid && !rst && valid_vec[f_idx] && (tag_vec[f_idx] == f_tag)) begin
            f_hit        = 1'b1;
            f_pred_taken = ctr_vec[f_idx][1];
            if (ctr_vec[f_idx][1]) begin
                f_next_pc = {target_vec[f_idx], 1'b0};
            end
        end
    end

    // Training decision for the slot addressed by ex_pc.
    logic             slot_we;
    logic             slot_valid_next;
    logic [TAG_W-1:0] slot_tag_next;
    logic [XLEN-2:0]  slot_target_next;
    logic [1:0]       slot_ctr_next;
    logic [1:0]       cur_ctr;
    assign cur_ctr = ctr_vec[ex_idx];

    // Decide whether/how the indexed slot changes this cycle
    always_comb begin
        slot_we          = 1'b0;
        slot_valid_next  = valid_vec[ex_idx];
        slot_tag_next    = tag_vec[ex_idx];
        slot_target_next = target_vec[ex_idx];
        slot_ctr_next    = cur_ctr;
        if (ex_valid && ex_is_ctrl) begin
            if (ex_hit) begin
                slot_we = 1'b1;
                if (ex_is_jump) begin
                    slot_ctr_next = 2'b11;
                end else if (ex_taken) begin
                    slot_ctr_next = (cur_ctr == 2'b11) ? 2'b11 : cur_ctr + 2'd1;
                end else begin
                    slot_ctr_next = (cur_ctr == 2'b00) ? 2'b00 : cur_ctr - 2'd1;
                end
                if (ex_taken) begin
                    slot_target_next = ex_target[XLEN-1:1];
                end
            end else if (ex_taken) begin
                // Allocate, evicting whatever aliased into this slot
                slot_we          = 1'b1;
                slot_valid_next  = 1'b1;
                slot_tag_next    = ex_tag;
                slot_target_next = ex_target[XLEN-1:1];
                slot_ctr_next    = ex_is_jump ? 2'b11 : CTR_INIT;
            end
        end else if (ex_valid && ex_pred_taken && ex_hit) begin
            // A non-branch was predicted taken: the entry is stale
            slot_we         = 1'b1;
            slot_valid_next = 1'b0;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < ENTRIES; gi++) begin : g_entry
            logic             valid_reg;
            logic [TAG_W-1:0] tag_reg;
            logic [XLEN-2:0]  target_reg;
            logic [1:0]       ctr_reg;

            // Entry storage: cleared on reset, written when training selects it
            always_ff @(posedge clk) begin
                if (rst) begin
                    valid_reg  <= 1'b0;
                    tag_reg    <= '0;
                    target_reg <= '0;
                    ctr_reg    <= CTR_INIT;
                end else if (slot_we && (ex_idx == IDX_W'(gi))) begin
                    valid_reg  <= slot_valid_next;
                    tag_reg    <= slot_tag_next;
                    target_reg <= slot_target_next;
                    ctr_reg    <= slot_ctr_next;
                end
            end

            assign valid_vec[gi]  = valid_reg;
            assign tag_vec[gi]    = tag_reg;
            assign target_vec[gi] = target_reg;
            assign ctr_vec[gi]    = ctr_reg;
        end
    endgenerate

    // Mispredict detection and the architecturally correct next PC
    logic            mp_next;
    logic [XLEN-1:0] correct_pc;
    always_comb begin
        mp_next = 1'b0;
        if (ex_valid) begin
            if (ex_is_ctrl) begin
                mp_next = (ex_taken != ex_pred_taken) ||
                          (ex_taken && (ex_target_m != ex_pred_target));
            end else begin
                mp_next = ex_pred_taken;
            end
        end
        correct_pc = (ex_is_ctrl && ex_taken) ? ex_target_m : ex_pc + XLEN'(4);
    end

    logic            mispredict_reg;
    logic [XLEN-1:0] redirect_pc_reg;

    // Registered redirect: one-cycle pulse, PC held between events
    always_ff @(posedge clk) begin
        if (rst) begin
            mispredict_reg  <= 1'b0;
            redirect_pc_reg <= '0;
        end else begin
            mispredict_reg <= mp_next;
            if (mp_next) begin
                redirect_pc_reg <= correct_pc;
            end
        end
    end

    logic [CNT_W-1:0] cnt_ctrl_reg;
    logic [CNT_W-1:0] cnt_mispred_reg;

    // Saturating performance counters
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_ctrl_reg    <= '0;
            cnt_mispred_reg <= '0;
        end else begin
            if (ex_valid && ex_is_ctrl && (cnt_ctrl_reg != CNT_MAX)) begin
                cnt_ctrl_reg <= cnt_ctrl_reg + CNT_W'(1);
            end
            if (mp_next && (cnt_mispred_reg != CNT_MAX)) begin
                cnt_mispred_reg <= cnt_mispred_reg + CNT_W'(1);
            end
        end
    end

    assign mispredict  = mispredict_reg;
    assign redirect_pc = redirect_pc_reg;
    assign cnt_ctrl    = cnt_ctrl_reg;
    assign cnt_mispred = cnt_mispred_reg;

endmodule

// File: tb/tb_branch_target_predictor.sv
// Bench for branch_target_predictor: directed scenarios with literal
// expectations, then a randomized run checked every cycle against a
// behavioural model of the predictor table and counters.
module tb_branch_target_predictor;

    localparam int XLEN    = 32;
    localparam int ENTRIES = 16;
    localparam int CNT_W   = 4;
    localparam int CNT_MAX = 15;

    logic              clk = 1'b0;
    logic              rst;
    logic              f_valid;
    logic [XLEN-1:0]   f_pc;
    logic              f_hit;
    logic              f_pred_taken;
    logic [XLEN-1:0]   f_next_pc;
    logic              ex_valid;
    logic [XLEN-1:0]   ex_pc;
    logic              ex_is_ctrl;
    logic              ex_is_jump;
    logic              ex_taken;
    logic [XLEN-1:0]   ex_target;
    logic              ex_pred_taken;
    logic [XLEN-1:0]   ex_pred_target;
    logic              mispredict;
    logic [XLEN-1:0]   redirect_pc;
    logic [CNT_W-1:0]  cnt_ctrl;
    logic [CNT_W-1:0]  cnt_mispred;

    branch_target_predictor #(
        .XLEN(XLEN), .ENTRIES(ENTRIES), .CTR_INIT(2'b10), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst(rst),
        .f_valid(f_valid), .f_pc(f_pc),
        .f_hit(f_hit), .f_pred_taken(f_pred_taken), .f_next_pc(f_next_pc),
        .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_is_ctrl(ex_is_ctrl),
        .ex_is_jump(ex_is_jump), .ex_taken(ex_taken), .ex_target(ex_target),
        .ex_pred_taken(ex_pred_taken), .ex_pred_target(ex_pred_target),
        .mispredict(mispredict), .redirect_pc(redirect_pc),
        .cnt_ctrl(cnt_ctrl), .cnt_mispred(cnt_mispred)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_pass  = 0;
    bit check_en = 1'b0;

    // ---------------- behavioural model ----------------
    bit          m_valid  [ENTRIES];
    logic [31:0] m_tag    [ENTRIES];
    logic [31:0] m_target [ENTRIES];
    int          m_ctr    [ENTRIES];
    bit          m_mp;
    logic [31:0] m_redir;
    int          m_cnt_ctrl;
    int          m_cnt_mp;

    function automatic int idx_of(input logic [31:0] pc);
        return int'((pc / 4) % ENTRIES);
    endfunction

    function automatic logic [31:0] tag_of(input logic [31:0] pc);
        return pc / (4 * ENTRIES);
    endfunction

    // What fetch must see for a given PC, from the model table
    task automatic model_lookup(input bit en, input logic [31:0] pc,
                                output bit hit, output bit pt, output logic [31:0] nxt);
        int i;
        i   = idx_of(pc);
        hit = en && m_valid[i] && (m_tag[i] == tag_of(pc));
        pt  = hit && (m_ctr[i] >= 2);
        nxt = pt ? m_target[i] : pc + 32'd4;
    endtask

    // Apply one clock edge worth of architectural effects
    task automatic model_update();
        int i;
        bit hit, ctrl, mp;
        logic [31:0] tgt;
        if (rst) begin
            for (int k = 0; k < ENTRIES; k++) begin
                m_valid[k] = 0; m_tag[k] = 0; m_target[k] = 0; m_ctr[k] = 2;
            end
            m_mp = 0; m_redir = 0; m_cnt_ctrl = 0; m_cnt_mp = 0;
            return;
        end
        i    = idx_of(ex_pc);
        tgt  = ex_target & ~32'd1;
        hit  = m_valid[i] && (m_tag[i] == tag_of(ex_pc));
        ctrl = ex_valid && ex_is_ctrl;
        if (ctrl) mp = (ex_taken != ex_pred_taken) || (ex_taken && tgt != ex_pred_target);
        else      mp = ex_valid && ex_pred_taken;
        m_mp = mp;
        if (mp) m_redir = (ex_is_ctrl && ex_taken) ? tgt : ex_pc + 32'd4;
        if (ctrl && m_cnt_ctrl < CNT_MAX) m_cnt_ctrl++;
        if (mp && m_cnt_mp < CNT_MAX) m_cnt_mp++;
        if (ctrl) begin
            if (hit) begin
                if (ex_is_jump)    m_ctr[i] = 3;
                else if (ex_taken) m_ctr[i] = (m_ctr[i] < 3) ? m_ctr[i] + 1 : 3;
                else               m_ctr[i] = (m_ctr[i] > 0) ? m_ctr[i] - 1 : 0;
                if (ex_taken) m_target[i] = tgt;
            end else if (ex_taken) begin
                m_valid[i]  = 1;
                m_tag[i]    = tag_of(ex_pc);
                m_target[i] = tgt;
                m_ctr[i]    = ex_is_jump ? 3 : 2;
            end
        end else if (ex_valid && ex_pred_taken && hit) begin
            m_valid[i] = 0;
        end
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Per-cycle comparison against the model, away from the active edge
    always @(negedge clk) begin
        if (check_en) begin
            bit eh, ept;
            logic [31:0] enx;
            model_lookup(f_valid && !rst, f_pc, eh, ept, enx);
            chk("f_hit",        64'(f_hit),        64'(eh));
            chk("f_pred_taken", 64'(f_pred_taken), 64'(ept));
            chk("f_next_pc",    64'(f_next_pc),    64'(enx));
            chk("mispredict",   64'(mispredict),   64'(m_mp));
            chk("redirect_pc",  64'(redirect_pc),  64'(m_redir));
            chk("cnt_ctrl",     64'(cnt_ctrl),     64'(m_cnt_ctrl));
            chk("cnt_mispred",  64'(cnt_mispred),  64'(m_cnt_mp));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        model_update();
        @(negedge clk);
        #1;
    endtask

    task automatic ex_set(input bit v, input bit ctrl, input bit jmp, input bit tk,
                          input logic [31:0] pc, input logic [31:0] tgt,
                          input bit pt, input logic [31:0] ptgt);
        ex_valid = v; ex_is_ctrl = ctrl; ex_is_jump = jmp; ex_taken = tk;
        ex_pc = pc; ex_target = tgt; ex_pred_taken = pt; ex_pred_target = ptgt;
    endtask

    task automatic lookup(input logic [31:0] pc);
        f_valid = 1'b1;
        f_pc    = pc;
        #1;
    endtask

    function automatic logic [31:0] rand_pc();
        logic [31:0] tags [4];
        logic [31:0] t;
        tags[0] = 32'd4; tags[1] = 32'd5; tags[2] = 32'd6; tags[3] = 32'h03FF_FFFF;
        t = tags[$urandom_range(0, 3)];
        return (t << 6) | (32'($urandom_range(0, ENTRIES - 1)) << 2) | 32'($urandom_range(0, 3));
    endfunction

    initial begin
        rst = 1'b1; f_valid = 1'b0; f_pc = '0;
        ex_set(0, 0, 0, 0, 0, 0, 0, 0);
        tick(); tick();
        check_en = 1'b1;
        rst = 1'b0;

        // Reset state and cold lookup
        lookup(32'h100);
        chk("reset_f_hit", 64'(f_hit), 64'd0);
        chk("reset_next_pc", 64'(f_next_pc), 64'h104);
        chk("reset_cnt_ctrl", 64'(cnt_ctrl), 64'd0);
        chk("reset_cnt_mispred", 64'(cnt_mispred), 64'd0);
        chk("reset_mispredict", 64'(mispredict), 64'd0);

        // Taken branch allocates and redirects
        ex_set(1, 1, 0, 1, 32'h100, 32'h200, 0, 32'h104);
        tick(); ex_valid = 0;
        chk("alloc_mp", 64'(mispredict), 64'd1);
        chk("alloc_redirect", 64'(redirect_pc), 64'h200);
        chk("alloc_cnt_mp", 64'(cnt_mispred), 64'd1);
        lookup(32'h100);
        chk("alloc_hit", 64'(f_hit), 64'd1);
        chk("alloc_pt", 64'(f_pred_taken), 64'd1);
        chk("alloc_next", 64'(f_next_pc), 64'h200);

        // Two not-taken resolves walk ctr 2->1->0
        ex_set(1, 1, 0, 0, 32'h100, 32'h104, 1, 32'h200);
        tick();
        chk("nt1_mp", 64'(mispredict), 64'd1);
        chk("nt1_redirect", 64'(redirect_pc), 64'h104);
        ex_set(1, 1, 0, 0, 32'h100, 32'h104, 0, 32'h104);
        tick(); ex_valid = 0;
        chk("nt2_mp", 64'(mispredict), 64'd0);
        lookup(32'h100);
        chk("nt2_hit", 64'(f_hit), 64'd1);
        chk("nt2_pt", 64'(f_pred_taken), 64'd0);
        chk("nt2_next", 64'(f_next_pc), 64'h104);
        chk("nt2_cnt_ctrl", 64'(cnt_ctrl), 64'd3);
        chk("nt2_cnt_mp", 64'(cnt_mispred), 64'd2);

        // JALR with odd target: bit 0 masked, no mispredict, ctr=3
        ex_set(1, 1, 1, 1, 32'h40, 32'h301, 1, 32'h300);
        tick(); ex_valid = 0;
        chk("jalr_mp", 64'(mispredict), 64'd0);
        lookup(32'h40);
        chk("jalr_pt", 64'(f_pred_taken), 64'd1);
        chk("jalr_next", 64'(f_next_pc), 64'h300);

        // Aliasing into slot 0, then stale-entry invalidation
        ex_set(1, 1, 0, 1, 32'h140, 32'h500, 0, 32'h144);
        tick(); ex_valid = 0;
        chk("alias_redirect", 64'(redirect_pc), 64'h500);
        lookup(32'h100);
        chk("alias_old_miss", 64'(f_hit), 64'd0);
        lookup(32'h140);
        chk("alias_new_next", 64'(f_next_pc), 64'h500);
        ex_set(1, 0, 0, 0, 32'h140, 32'h0, 1, 32'h500);
        tick(); ex_valid = 0;
        chk("stale_mp", 64'(mispredict), 64'd1);
        chk("stale_redirect", 64'(redirect_pc), 64'h144);
        lookup(32'h140);
        chk("stale_miss", 64'(f_hit), 64'd0);

        // Back-to-back mispredicts drive cnt_mispred into saturation
        for (int k = 0; k < 14; k++) begin
            ex_set(1, 0, 0, 0, 32'h80, 32'h0, 1, 32'h84);
            tick();
            chk("b2b_mp", 64'(mispredict), 64'd1);
        end
        ex_valid = 0;
        chk("sat_cnt_mp", 64'(cnt_mispred), 64'd15);
        chk("sat_cnt_ctrl", 64'(cnt_ctrl), 64'd5);

        // Reset coinciding with a mispredicting resolve
        ex_set(1, 1, 0, 1, 32'h100, 32'h900, 0, 32'h104);
        rst = 1'b1;
        tick();
        chk("rst_mp", 64'(mispredict), 64'd0);
        chk("rst_cnt_ctrl", 64'(cnt_ctrl), 64'd0);
        chk("rst_cnt_mp", 64'(cnt_mispred), 64'd0);
        lookup(32'h40);
        chk("rst_held_hit", 64'(f_hit), 64'd0);
        chk("rst_held_next", 64'(f_next_pc), 64'h44);
        rst = 1'b0; ex_valid = 0;
        #1;
        chk("rst_cleared_hit", 64'(f_hit), 64'd0);

        // PC+4 wrap on both ports
        ex_set(1, 1, 0, 1, 32'h100, 32'h200, 0, 32'h104);
        tick();
        f_valid = 1'b0; f_pc = 32'hFFFF_FFFC; #1;
        chk("wrap_f_next", 64'(f_next_pc), 64'h0);
        ex_set(1, 0, 0, 0, 32'hFFFF_FFFC, 32'h0, 1, 32'h8);
        tick(); ex_valid = 0;
        chk("wrap_redirect", 64'(redirect_pc), 64'h0);

        // Randomized run against the model
        for (int c = 0; c < 4000; c++) begin
            bit hit, pt;
            logic [31:0] nxt;
            rst     = ($urandom_range(0, 199) == 0);
            f_valid = ($urandom_range(0, 3) != 0);
            f_pc    = rand_pc();
            ex_valid   = ($urandom_range(0, 4) != 0);
            ex_pc      = rand_pc();
            ex_is_ctrl = ($urandom_range(0, 9) < 7);
            ex_is_jump = ($urandom_range(0, 3) == 0);
            ex_taken   = $urandom_range(0, 1);
            ex_target  = ($urandom_range(0, 1) == 1) ? rand_pc() : $urandom;
            if ($urandom_range(0, 9) < 6) begin
                model_lookup(1'b1, ex_pc, hit, pt, nxt);
                ex_pred_taken  = pt;
                ex_pred_target = ($urandom_range(0, 5) == 0) ? ex_target : nxt;
            end else begin
                ex_pred_taken  = $urandom_range(0, 1);
                ex_pred_target = ex_target & ~32'd1;
            end
            tick();
        end
        rst = 1'b0; ex_valid = 1'b0;
        tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
